// File: rtl/serial_and_reduce_pkg.sv
// Shared types and sizing helpers for the serial AND reducer.
// No logic; no latency.
// No flow control of its own.
package serial_and_reduce_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int LEN_DEFAULT = 8;

    // Width needed to index every bit of a LEN-bit frame (at least 1 bit).
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/serial_and_reduce_acc_and_cell.sv
// Two-input AND built from a single 2:1 mux and a constant.
// Combinational, zero latency.
// No flow control.
module acc_and_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = b ? a : 1'b0;

endmodule

// File: rtl/serial_and_reduce.sv
// Serial AND reducer: folds LEN accepted stream bits into one registered result.
// Latency: result valid on the edge accepting the LEN-th bit; optional SERIAL_AND_REDUCE_FIRST_ZERO_EN adds down_zero_idx.
// Backpressure: up_ready follows down_ready while a result is held, so frames run back-to-back.
module serial_and_reduce
    import serial_and_reduce_pkg::*;
#(
    parameter  int LEN = LEN_DEFAULT,
    localparam int CW  = cnt_width(LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic          up_data,
    output logic          up_ready,
    output logic          down_valid,
    output logic          down_data,
    input  logic          down_ready
`ifdef SERIAL_AND_REDUCE_FIRST_ZERO_EN
    ,
    output logic [CW-1:0] down_zero_idx
`endif
);

    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    state_t        state_q;
    state_t        state_d;
    logic          acc_q;
    logic          acc_next;
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          frame_end;

    acc_and_cell u_acc_and_cell (
        .a (acc_q),
        .b (up_data),
        .y (acc_next)
    );

    // cnt is 0 in HOLD and LEN >= 2, so a frame can only end from ACCUM.
    always_comb begin
        up_ready = 1'b0;
        state_d  = state_q;
        if (!rst) begin
            case (state_q)
                ACCUM:   up_ready = 1'b1;
                HOLD:    up_ready = down_ready;
                default: up_ready = 1'b0;
            endcase
        end
        accept    = up_valid & up_ready;
        frame_end = accept && (cnt_q == LAST);
        case (state_q)
            ACCUM:   if (frame_end)  state_d = HOLD;
            HOLD:    if (down_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= 1'b1;
            cnt_q      <= '0;
            down_valid <= 1'b0;
            down_data  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (down_valid && down_ready) begin
                down_valid <= 1'b0;
            end
            if (frame_end) begin
                down_valid <= 1'b1;
                down_data  <= acc_next;
                acc_q      <= 1'b1;
                cnt_q      <= '0;
            end else if (accept) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

`ifdef SERIAL_AND_REDUCE_FIRST_ZERO_EN
    logic [CW-1:0] zero_idx_q;

    // acc_q still 1 means no zero seen yet this frame, so it doubles as the "first zero" flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_idx_q    <= '0;
            down_zero_idx <= '0;
        end else begin
            if (accept && acc_q && !up_data) begin
                zero_idx_q <= cnt_q;
            end
            if (frame_end) begin
                down_zero_idx <= !acc_q ? zero_idx_q : (up_data ? {CW{1'b0}} : cnt_q);
            end
        end
    end
`endif

endmodule
